// File: rtl/serial_adder_pkg.sv
// Shared state encoding and width helpers for the bit-serial adder.
// Optional signed-overflow output is enabled by SERIAL_ADDER_OVF_EN.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Bit-counter width for a W-bit operand; never below one bit.
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/fa_bit.sv
// One-bit combinational full adder: the cell consumed once per clock by serial_adder.
module fa_bit (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum_c,
    output logic carry_c
);

    assign sum_c   = a ^ b ^ c;
    assign carry_c = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial W-bit adder, LSB first, one full-adder cell and a carry flop.
// Define SERIAL_ADDER_OVF_EN to add the registered two's-complement overflow output ovf.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] sum,
    output logic         cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic         ovf
`endif
);

    localparam int unsigned CNT_W = cnt_width(W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

    state_t           state_q;
    state_t           state_d;
    logic             load_c;
    logic             shift_c;
    logic             last_c;

    logic [W-1:0]     opa_q;
    logic [W-1:0]     opb_q;
    logic [W-2:0]     res_q;
    logic [W-1:0]     res_next;
    logic             carry_q;
    logic [CNT_W-1:0] cnt_q;

    logic             fa_sum;
    logic             fa_carry;

    fa_bit u_fa_bit (
        .a       (opa_q[0]),
        .b       (opb_q[0]),
        .c       (carry_q),
        .sum_c   (fa_sum),
        .carry_c (fa_carry)
    );

    // Newest sum bit enters at the MSB; after W shifts this is the full result.
    assign res_next = {fa_sum, res_q};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath strobes.
    always_comb begin
        state_d = state_q;
        load_c  = 1'b0;
        shift_c = 1'b0;
        last_c  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    load_c  = 1'b1;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                shift_c = 1'b1;
                if (cnt_q == CNT_LAST) begin
                    last_c  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Status outputs are flopped copies of the next-state decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_d == ST_SHIFT);
            done <= (state_d == ST_DONE);
        end
    end

    // Operand/result shift registers, carry flop and bit counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opa_q   <= '0;
            opb_q   <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else if (load_c) begin
            opa_q   <= a;
            opb_q   <= b;
            carry_q <= cin;
            cnt_q   <= '0;
        end else if (shift_c) begin
            opa_q   <= {1'b0, opa_q[W-1:1]};
            opb_q   <= {1'b0, opb_q[W-1:1]};
            res_q   <= res_next[W-1:1];
            carry_q <= fa_carry;
            cnt_q   <= last_c ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // Result outputs change only when the final bit is produced.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum  <= '0;
            cout <= 1'b0;
        end else if (last_c) begin
            sum  <= res_next;
            cout <= fa_carry;
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    // On the last bit, carry_q is the carry into the MSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (last_c) begin
            ovf <= carry_q ^ fa_carry;
        end
    end
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder with a latency-level reference model and per-cycle compare.
module tb_serial_adder;

    localparam int unsigned W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic         ovf;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int dut_dones = 0;

    serial_adder #(.W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 idle, 1..W busy, W+1 done; result from plain addition.
    int           phase;
    logic [W:0]   pend;
    logic         pend_ovf;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
    logic         exp_ovf;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase    = 0;
            pend     = '0;
            pend_ovf = 1'b0;
            exp_sum  = '0;
            exp_cout = 1'b0;
            exp_ovf  = 1'b0;
        end else if (phase == 0) begin
            if (start) begin
                logic [W-1:0] low;
                pend = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
                low  = {1'b0, a[W-2:0]} + {1'b0, b[W-2:0]} + W'(cin);
                pend_ovf = low[W-1] ^ pend[W];
                phase = 1;
            end
        end else if (phase < W) begin
            phase++;
        end else if (phase == W) begin
            phase    = W + 1;
            exp_sum  = pend[W-1:0];
            exp_cout = pend[W];
            exp_ovf  = pend_ovf;
        end else begin
            phase = 0;
        end
    end

    // Per-cycle compare away from the active edge.
    always @(negedge clk) begin
        check("busy", 32'(busy), 32'(phase >= 1 && phase <= W));
        check("done", 32'(done), 32'(phase == W + 1));
        check("sum",  32'(sum),  32'(exp_sum));
        check("cout", 32'(cout), 32'(exp_cout));
`ifdef SERIAL_ADDER_OVF_EN
        check("ovf",  32'(ovf),  32'(exp_ovf));
`endif
        if (done) dut_dones++;
    end

    task automatic wait_done(input string name);
        bit seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                break;
            end
        end
        check({name, "_done_timeout"}, 32'(seen), 32'd1);
    endtask

    task automatic run_op(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic tc, input logic [W-1:0] es, input logic ec);
        @(negedge clk);
        a = ta; b = tb; cin = tc; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = ~ta; b = ~tb; cin = ~tc;
        wait_done(name);
        check({name, "_sum"},  32'(sum),     32'(es));
        check({name, "_cout"}, 32'(cout),    32'(ec));
        check({name, "_msum"}, 32'(exp_sum), 32'(es));
        @(negedge clk);
    endtask

    initial begin
        int d0;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum",  32'(sum),  32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_op("add35_4a", 8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0);
        run_op("addff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        run_op("add00_cin", 8'h00, 8'h00, 1'b1, 8'h01, 1'b0);

        // Second start while busy must be ignored.
        d0 = dut_dones;
        @(negedge clk);
        a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = 8'h55;
        repeat (2) @(negedge clk);
        a = 8'hFF; b = 8'hFF; cin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("overlap");
        check("overlap_sum",  32'(sum),  32'h30);
        check("overlap_cout", 32'(cout), 32'd0);
        repeat (15) @(negedge clk);
        check("overlap_ndone", 32'(dut_dones - d0), 32'd1);

        // Start held high: one op per W+2 cycles.
        d0 = dut_dones;
        a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
        repeat (30) @(negedge clk);
        start = 1'b0;
        repeat (15) @(negedge clk);
        check("b2b_ndone", 32'(dut_dones - d0), 32'd3);
        check("b2b_sum",   32'(sum),            32'h02);

        // Reset in the middle of an operation.
        @(negedge clk);
        a = 8'hC3; b = 8'h3C; cin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_done", 32'(done), 32'd0);
        check("mrst_sum",  32'(sum),  32'd0);
        check("mrst_cout", 32'(cout), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        d0 = dut_dones;
        repeat (15) @(negedge clk);
        check("mrst_nodone", 32'(dut_dones - d0), 32'd0);

`ifdef SERIAL_ADDER_OVF_EN
        run_op("ovf_7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0);
        check("ovf_set", 32'(ovf), 32'd1);
        run_op("ovf_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        check("ovf_clr", 32'(ovf), 32'd0);
`endif

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
